// File: rtl/sort_pkg.sv
// Shared types and default widths for the exchange-sort sequencer.
package sort_pkg;

  localparam int SORT_SIZE_ADDR = 8;
  localparam int SORT_SIZE_DATA = 32;

  typedef enum logic [2:0] {
    IDLE, RD_I, LD_I, RD_J, CMP, WR_I, WR_J, DONE
  } sort_state_e;

endpackage

// File: rtl/sort_loop_idx.sv
// Outer/inner loop index registers for the exchange sort; j restarts at i+1
// whenever the inner loop wraps.
module sort_loop_idx
  import sort_pkg::*;
#(
  parameter int SIZE_ADDR = SORT_SIZE_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [SIZE_ADDR-1:0] r_n,
  output logic [SIZE_ADDR-1:0] i,
  output logic [SIZE_ADDR-1:0] j,
  output logic                 inner_last,
  output logic                 outer_last
);

  assign inner_last = (j == r_n - SIZE_ADDR'(1));
  assign outer_last = (i == r_n - SIZE_ADDR'(2));

  // j never exceeds r_n-1, so j+1 and i+2 cannot wrap the address width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i <= '0;
      j <= '0;
    end else if (load) begin
      i <= '0;
      j <= SIZE_ADDR'(1);
    end else if (advance) begin
      if (!inner_last) begin
        j <= j + SIZE_ADDR'(1);
      end else if (!outer_last) begin
        i <= i + SIZE_ADDR'(1);
        j <= i + SIZE_ADDR'(2);
      end
    end
  end

endmodule

// File: rtl/sort_ctrl.sv
// Exchange-sort sequencer driving a single-port synchronous RAM.
// Define SORT_CTRL_DESCEND_EN for a non-increasing result.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int SIZE_ADDR = SORT_SIZE_ADDR,
  parameter int SIZE_DATA = SORT_SIZE_DATA
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [SIZE_ADDR-1:0] o_mem_addr,
  output logic                 o_mem_rd,
  output logic                 o_mem_wr,
  output logic [SIZE_DATA-1:0] o_mem_wdata,
  input  logic [SIZE_DATA-1:0] i_mem_rdata
);

  sort_state_e          state;
  sort_state_e          adv_state;
  logic [SIZE_ADDR-1:0] r_n;
  logic [SIZE_ADDR-1:0] i;
  logic [SIZE_ADDR-1:0] j;
  logic [SIZE_ADDR-1:0] adv_addr;
  logic [SIZE_DATA-1:0] r_ai;
  logic [SIZE_DATA-1:0] r_aj;
  logic                 inner_last;
  logic                 outer_last;
  logic                 swap;
  logic                 load;
  logic                 advance;

`ifdef SORT_CTRL_DESCEND_EN
  assign swap = (i_mem_rdata > r_ai);
`else
  assign swap = (i_mem_rdata < r_ai);
`endif

  assign load    = (state == IDLE) && i_start && (i_num_elems > SIZE_ADDR'(1));
  assign advance = ((state == CMP) && !swap) || (state == WR_J);

  sort_loop_idx #(
    .SIZE_ADDR (SIZE_ADDR)
  ) u_idx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .load       (load),
    .advance    (advance),
    .r_n        (r_n),
    .i          (i),
    .j          (j),
    .inner_last (inner_last),
    .outer_last (outer_last)
  );

  // Outputs are registered, so the advance target must carry the address the
  // index registers will hold after this edge.
  always_comb begin
    adv_state = RD_J;
    adv_addr  = j + SIZE_ADDR'(1);
    if (inner_last) begin
      if (outer_last) begin
        adv_state = DONE;
        adv_addr  = '0;
      end else begin
        adv_state = RD_I;
        adv_addr  = i + SIZE_ADDR'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      r_n         <= '0;
      r_ai        <= '0;
      r_aj        <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_rd    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_wdata <= '0;
    end else begin
      o_done      <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_rd    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (i_num_elems > SIZE_ADDR'(1)) begin
              r_n      <= i_num_elems;
              state    <= RD_I;
              o_mem_rd <= 1'b1;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end
        RD_I: state <= LD_I;
        LD_I: begin
          r_ai       <= i_mem_rdata;
          state      <= RD_J;
          o_mem_rd   <= 1'b1;
          o_mem_addr <= j;
        end
        RD_J: state <= CMP;
        CMP: begin
          r_aj <= i_mem_rdata;
          if (swap) begin
            state       <= WR_I;
            o_mem_wr    <= 1'b1;
            o_mem_addr  <= i;
            o_mem_wdata <= i_mem_rdata;
          end else begin
            state      <= adv_state;
            o_mem_rd   <= (adv_state != DONE);
            o_mem_addr <= adv_addr;
            o_done     <= (adv_state == DONE);
          end
        end
        WR_I: begin
          state       <= WR_J;
          o_mem_wr    <= 1'b1;
          o_mem_addr  <= j;
          o_mem_wdata <= r_ai;
        end
        // The new A[i] is the value just moved down, so no re-read is needed.
        WR_J: begin
          r_ai       <= r_aj;
          state      <= adv_state;
          o_mem_rd   <= (adv_state != DONE);
          o_mem_addr <= adv_addr;
          o_done     <= (adv_state == DONE);
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: RAM model plus a behavioural sort model.
// Honours SORT_CTRL_DESCEND_EN in its reference model.
module tb_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_elems = 8'd0;
  logic        busy, done, rd, wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata = 32'd0;

  logic [31:0] ram     [0:255];
  logic [31:0] exp_arr [0:255];
  logic [7:0]  wlog_a  [0:15];
  logic [31:0] wlog_d  [0:15];

  int n_cmp = 0, n_bad = 0;
  int rd_cnt, wr_cnt, both_cnt, done_cnt, busy_gap, cyc, done_cyc;
  int exp_rd, exp_wr, exp_cyc;
  bit running = 1'b0;

  always #5 clk = ~clk;

  sort_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_num_elems (num_elems),
    .o_busy      (busy),
    .o_done      (done),
    .o_mem_addr  (addr),
    .o_mem_rd    (rd),
    .o_mem_wr    (wr),
    .o_mem_wdata (wdata),
    .i_mem_rdata (rdata)
  );

  // Single-port synchronous RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (wr) ram[addr] = wdata;
    if (rd) rdata <= ram[addr];
  end

  always @(negedge clk) begin
    if (running) begin
      cyc++;
      if (rd) rd_cnt++;
      if (wr) begin
        if (wr_cnt < 16) begin
          wlog_a[wr_cnt] = addr;
          wlog_d[wr_cnt] = wdata;
        end
        wr_cnt++;
      end
      if (rd && wr) both_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (!busy && done_cnt == 0) busy_gap++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain exchange sort on exp_arr; equal values never swap.
  task automatic refModel(input int n);
    int swaps;
    logic [31:0] t;
    swaps = 0;
    for (int a = 0; a < n - 1; a++)
      for (int b = a + 1; b < n; b++) begin
`ifdef SORT_CTRL_DESCEND_EN
        if (exp_arr[b] > exp_arr[a]) begin
`else
        if (exp_arr[b] < exp_arr[a]) begin
`endif
          t = exp_arr[a]; exp_arr[a] = exp_arr[b]; exp_arr[b] = t;
          swaps++;
        end
      end
    exp_wr  = 2 * swaps;
    exp_rd  = (n >= 2) ? (n - 1) + n * (n - 1) / 2 : 0;
    exp_cyc = (n >= 2) ? 2 * (n - 1) + n * (n - 1) + 2 * swaps + 1 : 1;
  endtask

  task automatic setElem(input int k, input logic [31:0] v);
    ram[k] = v;
    exp_arr[k] = v;
  endtask

  task automatic applyStimulus(input string tag, input int n, input bit disturb);
    int guard;
    refModel(n);
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0;
    busy_gap = 0; cyc = 0; done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    num_elems = n[7:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    running = 1'b1;
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (disturb && guard == 4) begin start = 1'b1; num_elems = 8'd3; end
      if (disturb && guard == 6) begin start = 1'b0; num_elems = n[7:0]; end
    end
    repeat (3) @(negedge clk);
    running = 1'b0;
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s ram[%0d]", tag, k), 64'(ram[k]), 64'(exp_arr[k]));
    checkOutput({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    checkOutput({tag, " reads"}, 64'(rd_cnt), 64'(exp_rd));
    checkOutput({tag, " writes"}, 64'(wr_cnt), 64'(exp_wr));
    checkOutput({tag, " rd_and_wr"}, 64'(both_cnt), 64'd0);
    checkOutput({tag, " busy_gap"}, 64'(busy_gap), 64'd0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 256; k++) setElem(k, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", 64'({busy, done, rd, wr, addr, wdata}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    setElem(0, 32'd5); setElem(1, 32'd3);
    applyStimulus("n2", 2, 1'b0);
    checkOutput("n2 wr0", {24'd0, wlog_a[0], wlog_d[0]}, {24'd0, 8'd0, 32'd3});
    checkOutput("n2 wr1", {24'd0, wlog_a[1], wlog_d[1]}, {24'd0, 8'd1, 32'd5});

    for (int k = 0; k < 4; k++) setElem(k, 32'(4 - k));
    applyStimulus("n4 reversed", 4, 1'b0);

    for (int k = 0; k < 5; k++) setElem(k, 32'(k + 1));
    applyStimulus("n5 sorted", 5, 1'b0);

    applyStimulus("n0", 0, 1'b0);
    applyStimulus("n1", 1, 1'b0);

    setElem(0, 32'd2); setElem(1, 32'd7); setElem(2, 32'd7); setElem(3, 32'd1);
    applyStimulus("n4 dup", 4, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(2, 12);
      for (int k = 0; k < n; k++) setElem(k, 32'($urandom_range(0, 15)));
      setElem(n - 1, $urandom());
      applyStimulus($sformatf("rand%0d", r), n, 1'b0);
    end

    for (int k = 0; k < 7; k++) setElem(k, 32'($urandom_range(0, 1000)));
    applyStimulus("disturb", 7, 1'b1);

    for (int k = 0; k < 8; k++) setElem(k, 32'($urandom_range(0, 99)));
    @(negedge clk);
    start = 1'b1;
    num_elems = 8'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset outputs", 64'({busy, done, rd, wr, addr, wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) setElem(k, 32'($urandom_range(0, 99)));
    applyStimulus("after reset", 8, 1'b0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
